// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the execute stage.
// One op per start: 32-step shift-add multiply or restoring divide, then sign fixup.
module ex_muldiv_seq #(
  parameter bit SPECIAL_FAST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        kill,
  input  logic [2:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [2:0]  op_q;
  logic [31:0] opb_q;
  logic [63:0] acc_q;
  logic        neg_q, sgn1_q, spec_q;
  logic [31:0] spec_res_q;
  logic [31:0] result_q, result_d;
  logic        done_q;

  logic        s1_in, s2_in, dz_in, ovf_in, spec_in, accept;
  logic [31:0] mag1_in, mag2_in, spec_res_in;
  logic [32:0] mul_sum;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] acc_step, prod;
  logic [31:0] quo, rem, fix_res;

  // Operand decode at launch: signedness, magnitudes and the early-out cases
  always_comb begin
    s1_in = 1'b0;
    s2_in = 1'b0;
    case (op)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        s1_in = 1'b1;
        s2_in = 1'b1;
      end
      3'b010:  s1_in = 1'b1;
      default: ;
    endcase
    mag1_in     = (s1_in && src1[31]) ? (~src1 + 32'd1) : src1;
    mag2_in     = (s2_in && src2[31]) ? (~src2 + 32'd1) : src2;
    dz_in       = op[2] && (src2 == '0);
    ovf_in      = op[2] && !op[0] && (src1 == 32'h8000_0000) && (src2 == '1);
    spec_in     = dz_in || ovf_in;
    spec_res_in = dz_in ? (op[1] ? src1 : '1) : (op[1] ? '0 : 32'h8000_0000);
  end

  // One iteration: acc holds {partial, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    div_ge   = acc_q[63:31] >= {1'b0, opb_q};
    div_diff = acc_q[62:31] - opb_q;
    if (op_q[2])
      acc_step = div_ge ? {div_diff, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};
    else
      acc_step = {mul_sum, acc_q[31:1]};
  end

  always_comb begin
    prod = neg_q ? (~acc_q + 64'd1) : acc_q;
    quo  = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem  = sgn1_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    if (spec_q)
      fix_res = spec_res_q;
    else if (op_q[2])
      fix_res = op_q[1] ? rem : quo;
    else
      fix_res = (op_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = (SPECIAL_FAST && spec_in) ? S_DONE : S_CALC;
        else       state_d = S_IDLE;
      end
      S_CALC:  if (cnt_q == 5'd31) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (kill) state_d = S_IDLE;
  end

  always_comb begin
    busy   = (state_q == S_CALC) || (state_q == S_FIX);
    done   = done_q;
    result = result_q;
  end

  assign accept = start && !kill && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Entering DONE from FIX takes the computed value; from IDLE/DONE it is a fast special case
  always_comb begin
    result_d = result_q;
    if (state_d == S_DONE)
      result_d = (state_q == S_FIX) ? fix_res : spec_res_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q   <= '0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      op_q       <= '0;
      opb_q      <= '0;
      acc_q      <= '0;
      neg_q      <= 1'b0;
      sgn1_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
    end else begin
      done_q   <= (state_d == S_DONE);
      result_q <= result_d;
      if (accept) begin
        op_q       <= op;
        opb_q      <= mag2_in;
        acc_q      <= {32'd0, mag1_in};
        cnt_q      <= '0;
        neg_q      <= (s1_in & src1[31]) ^ (s2_in & src2[31]);
        sgn1_q     <= s1_in & src1[31];
        spec_q     <= spec_in;
        spec_res_q <= spec_res_in;
      end else if (state_q == S_CALC) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Bench for ex_muldiv_seq: a fast-special and a full-length instance share stimulus.
module tb_ex_muldiv_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, kill;
  logic [2:0]  op;
  logic [31:0] src1, src2;
  logic        busy_f, done_f, busy_s, done_s;
  logic [31:0] res_f, res_s;

  ex_muldiv_seq #(.SPECIAL_FAST(1'b1)) dut_f (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .op(op),
    .src1(src1), .src2(src2), .busy(busy_f), .done(done_f), .result(res_f)
  );
  ex_muldiv_seq #(.SPECIAL_FAST(1'b0)) dut_s (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .op(op),
    .src1(src1), .src2(src2), .busy(busy_s), .done(done_s), .result(res_s)
  );

  int vectors = 0;
  int miscompares = 0;

  int          dcyc[2], bcnt[2], rchg[2], ovl[2];
  logic [31:0] dres[2], lr[2];
  logic        lb[2], ld[2];
  logic [2:0]  nx_op;
  logic [31:0] nx_a, nx_b;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a, b, exp;
    bit          sp;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = '0;
    r  = '0;
    case (o)
      3'd0: begin p = ua * ub; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: if (b == 0) r = '1; else begin p = sa / sb; r = p[31:0]; end
      3'd5: if (b == 0) r = '1; else begin p = ua / ub; r = p[31:0]; end
      3'd6: if (b == 0) r = a;  else begin p = sa % sb; r = p[31:0]; end
      default: if (b == 0) r = a; else begin p = ua % ub; r = p[31:0]; end
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return o[2] && ((b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Observe both instances for ncyc cycles after a launch; optionally inject kill/start/rst
  task automatic watch(input int ncyc, input int inj_c, input int inj_k);
    logic [31:0] prev[2];
    prev[0] = res_f;
    prev[1] = res_s;
    for (int d = 0; d < 2; d++) begin
      dcyc[d] = 0; bcnt[d] = 0; rchg[d] = 0; ovl[d] = 0; dres[d] = '0;
    end
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      lb[0] = busy_f; ld[0] = done_f; lr[0] = res_f;
      lb[1] = busy_s; ld[1] = done_s; lr[1] = res_s;
      for (int d = 0; d < 2; d++) begin
        if (lb[d]) bcnt[d]++;
        if (lb[d] && ld[d]) ovl[d]++;
        if (ld[d] && dcyc[d] == 0) begin
          dcyc[d] = c;
          dres[d] = lr[d];
        end
        if (!ld[d] && lr[d] !== prev[d]) rchg[d]++;
        prev[d] = lr[d];
      end
      if (c == 1) begin
        start = 1'b0; kill = 1'b0;
        op = 3'($urandom); src1 = $urandom; src2 = $urandom;
      end
      if (c == inj_c) begin
        case (inj_k)
          1: kill = 1'b1;
          2: begin start = 1'b1; op = nx_op; src1 = nx_a; src2 = nx_b; end
          3: rst = 1'b1;
          default: ;
        endcase
      end
      if (c == inj_c + 1) begin
        start = 1'b0; kill = 1'b0; rst = 1'b0;
      end
    end
  endtask

  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic k);
    @(negedge clk);
    op = o; src1 = a; src2 = b; start = 1'b1; kill = k;
  endtask

  task automatic check_op(input string name, input logic [31:0] exp, input bit sp);
    int expc;
    string tag;
    for (int d = 0; d < 2; d++) begin
      tag  = $sformatf("%s/%s", name, (d == 0) ? "fast" : "slow");
      expc = (sp && d == 0) ? 1 : 34;
      chk({tag, " done_cycle"}, 32'(dcyc[d]), 32'(expc));
      chk({tag, " result"}, dres[d], exp);
      chk({tag, " busy_cycles"}, 32'(bcnt[d]), (sp && d == 0) ? 32'd0 : 32'd33);
      chk({tag, " stray_change_or_overlap"}, 32'(rchg[d] + ovl[d]), 32'd0);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit sp);
    launch(o, a, b, 1'b0);
    watch(40, 0, 0);
    check_op(name, exp, sp);
  endtask

  initial begin
    tbl[0]  = '{"mul_7xm3",      3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    tbl[1]  = '{"mulh_min",      3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0};
    tbl[2]  = '{"mulhu_ones",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    tbl[3]  = '{"mulhsu_ones",   3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    tbl[4]  = '{"div_m7_2",      3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0};
    tbl[5]  = '{"rem_m7_2",      3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0};
    tbl[6]  = '{"divu_100_7",    3'd5, 32'd100,        32'd7,         32'd14,        1'b0};
    tbl[7]  = '{"remu_100_7",    3'd7, 32'd100,        32'd7,         32'd2,         1'b0};
    tbl[8]  = '{"div_5_0",       3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1};
    tbl[9]  = '{"remu_5_0",      3'd7, 32'd5,          32'd0,         32'd5,         1'b1};
    tbl[10] = '{"div_ovf",       3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    tbl[11] = '{"rem_ovf",       3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1};
    tbl[12] = '{"divu_m5_0",     3'd5, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF, 1'b1};
    tbl[13] = '{"rem_m5_0",      3'd6, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 1'b1};

    rst = 1'b1; start = 1'b0; kill = 1'b0; op = '0; src1 = '0; src2 = '0;
    repeat (3) @(negedge clk);
    chk("reset busy_f", 32'(busy_f), 32'd0);
    chk("reset done_f", 32'(done_f), 32'd0);
    chk("reset result_f", res_f, 32'd0);
    chk("reset busy_s", 32'(busy_s), 32'd0);
    chk("reset done_s", 32'(done_s), 32'd0);
    chk("reset result_s", res_s, 32'd0);
    rst = 1'b0;

    foreach (tbl[i]) run_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].sp);

    // kill in cycle 10 of a DIV: drops to idle with no done and result untouched
    launch(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    watch(40, 10, 1);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("kill_div[%0d] done_cycle", d), 32'(dcyc[d]), 32'd0);
      chk($sformatf("kill_div[%0d] busy_cycles", d), 32'(bcnt[d]), 32'd10);
      chk($sformatf("kill_div[%0d] result_change", d), 32'(rchg[d]), 32'd0);
    end

    // start in cycle 5 of a MUL (a fast-special divide) must be ignored
    nx_op = 3'd5; nx_a = 32'd5; nx_b = 32'd0;
    launch(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
    watch(40, 5, 2);
    check_op("mul_ignore_start", 32'hFFFF_FFEB, 1'b0);

    // start and kill together: nothing launches
    launch(3'd4, 32'd5, 32'd0, 1'b1);
    watch(40, 0, 0);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("start_kill[%0d] done_cycle", d), 32'(dcyc[d]), 32'd0);
      chk($sformatf("start_kill[%0d] busy_cycles", d), 32'(bcnt[d]), 32'd0);
    end

    // back-to-back: second start issued in the first op's done cycle
    nx_op = 3'd5; nx_a = 32'd100; nx_b = 32'd7;
    launch(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
    watch(34, 34, 2);
    check_op("b2b_first", 32'hFFFF_FFEB, 1'b0);
    watch(40, 0, 0);
    check_op("b2b_second", 32'd14, 1'b0);

    // rst in cycle 20 of a MUL
    launch(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
    watch(21, 20, 3);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_mid[%0d] busy", d), 32'(lb[d]), 32'd0);
      chk($sformatf("rst_mid[%0d] done", d), 32'(ld[d]), 32'd0);
      chk($sformatf("rst_mid[%0d] result", d), lr[d], 32'd0);
      chk($sformatf("rst_mid[%0d] busy_cycles", d), 32'(bcnt[d]), 32'd20);
    end
    run_op("mulhu_3x5", 3'd3, 32'd3, 32'd5, 32'd0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      logic [2:0]  o;
      logic [31:0] a, b;
      int          r;
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      r = $urandom_range(0, 9);
      if (r == 0) b = '0;
      else if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (r == 2) b = 32'($urandom_range(1, 15));
      run_op($sformatf("rand%0d_op%0d", n, o), o, a, b, model(o, a, b), is_special(o, a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_seq.md
# ex_muldiv_seq

Iterative RV32M multiply/divide sequencer attached to the execute stage. It accepts one M-extension operation per start pulse and runs it as a 32-step shift-add multiply or shift-subtract divide. It then reports a held 32-bit result with a one-cycle done pulse. The execute stage derives its ready-go from busy/done: it holds the instruction in E while busy and advances on done. A branch or jump redirect from execute uses kill to abort a wrong-path operation.

## Interface

- SPECIAL_FAST, default 1: selects latency for divide-by-zero and signed-overflow cases.
  - 1: these cases complete in 1 cycle.
  - 0: these cases take the full-length path with identical results.
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high; clock clk
- start  in  1  launch op; sampled only when not busy
- kill  in  1  synchronous abort of the in-flight op (execute flush)
- op  in  3  funct3 encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- src1  in  32  rs1 value: multiplicand / dividend
- src2  in  32  rs2 value: multiplier / divisor
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse; result valid
- result  out  32  final value; held until the next accepted start

## Operation

- FSM states:
  - IDLE: accepts start.
  - CALC: 32 iterations; 5-bit step counter 0..31.
  - FIX: sign fixup and selection of the result half.
  - DONE: done=1 for one cycle; behaves as IDLE for start.
- Transition priority, high to low: rst, kill, start.
- op, src1 and src2 are registered at start. Input changes after start are ignored.
- Operand signedness:
  - MULH: both operands signed.
  - MULHSU: src1 signed, src2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - DIV, REM: both signed.
- Signed operands are converted to magnitudes at start, and the sign flags are recorded.
- Multiply:
  - Produces a 64-bit unsigned magnitude product.
  - FIX negates the 64-bit product (two's complement) when the sign flags differ.
  - MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].
- Divide:
  - Restoring algorithm on 32-bit magnitudes.
  - Quotient is negated if the sign flags differ.
  - Remainder takes the sign of the dividend.
- Divide by zero (src2==0):
  - DIV/DIVU: 0xFFFFFFFF.
  - REM/REMU: src1.
- Signed overflow (DIV/REM with src1=0x80000000 and src2=0xFFFFFFFF):
  - DIV: 0x80000000.
  - REM: 0.
- When SPECIAL_FAST=1, the special cases go IDLE -> DONE directly, and busy is never asserted.
- start while busy: ignored; the in-flight op is unaffected.
- kill:
  - Next state is IDLE; busy=0 next cycle.
  - No done pulse; result keeps its previous value.
- kill and start in the same cycle: kill wins, and the start is dropped.
- rst mid-operation: identical to kill, and additionally clears result.

## Timing

- Reset values: busy=0, done=0, result=0x00000000; FSM in IDLE.
- Normal op:
  - start sampled at the edge ending cycle 0.
  - Cycles 1-32: CALC.
  - Cycle 33: FIX.
  - Cycle 34: done=1, result valid, busy=0.
  - busy is high in cycles 1-33.
- Special case with SPECIAL_FAST=1: done=1 and result valid in cycle 1; busy stays 0.
- done is registered, is high for exactly one cycle per accepted op, and is never high while busy=1.
- result updates only in the cycle done rises and is stable otherwise.
- Back-to-back: a start in the done cycle is accepted. The next done for a normal op is then 34 cycles later.
- No combinational path from any input to busy, done or result.

## Test plan

- MUL, src1=7, src2=0xFFFFFFFD: busy high cycles 1-33; done in cycle 34 with result=0xFFFFFFEB.
- High-half multiplies:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Divides:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
  - REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF.
  - DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
  - Each done in cycle 34.
- Special cases with SPECIAL_FAST=1; each done in cycle 1 with busy never high:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF -> 0.
- Repeat the special cases with SPECIAL_FAST=0: same results, done in cycle 34.
- Abort and ignore rules:
  - kill in cycle 10 of a DIV: busy=0 in cycle 11, no done, result unchanged.
  - A start issued in cycle 5 of a MUL is ignored; the MUL's done still arrives in cycle 34.
  - start+kill in the same cycle: no op launched.
  - rst in cycle 20: busy=0, done=0, result=0 next cycle.
  - A following MULHU 3x5 completes normally with result 0.
